// File: rtl/gray_pkg.sv
// gray_pkg: shared FSM state type and binary-to-Gray helper for the Gray generator.
package gray_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} gray_gen_state_t;
  // Width-generic via a 32-bit container; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_skid_buf.sv
// gray_skid_buf: 2-entry valid/ready buffer whose in_ready depends only on its own occupancy.
module gray_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    level
);
  logic [DW-1:0] mem [2];
  logic wp, rp, push, pop;
  assign in_ready  = level != 2'd2;
  assign out_valid = level != 2'd0;
  assign out_data  = mem[rp];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      level  <= 2'd0;
    end else if (flush) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      level <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      level <= level + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/gray_code_generator.sv
// gray_code_generator: counts from start_val up/down for len steps and streams {gray, bin} words.
module gray_code_generator
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH:0]   len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic [WIDTH-1:0] out_bin,
  output logic             busy,
  output logic             done,
  output logic             err
);
  gray_gen_state_t state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0] remaining;
  logic dir_r, run, in_ready, push, pop;
  logic [1:0] level;
  logic [2*WIDTH-1:0] out_data;
  assign run  = state == RUN;
  assign push = run && in_ready;
  assign pop  = out_valid && out_ready;
  assign {out_gray, out_bin} = out_data;
  gray_skid_buf #(.DW(2*WIDTH)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .flush(abort),
    .in_valid(run),
    .in_ready(in_ready),
    .in_data({WIDTH'(bin2gray(32'(cnt))), cnt}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      dir_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (len == '0) err <= 1'b1;
            else begin
              dir_r     <= dir;
              cnt       <= start_val;
              remaining <= len;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
          RUN: if (push) begin
            cnt       <= dir_r ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
            remaining <= remaining - (WIDTH+1)'(1);
            if (remaining == (WIDTH+1)'(1)) state <= DRAIN;
          end
          // Last word leaves when the buffer holds exactly one entry and it is taken.
          DRAIN: if (pop && level == 2'd1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
